// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - turns LC-3 Mem_OE/Mem_WE strobes into timed async-SRAM cycles
module mem_access_sequencer #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [15:0]       MAR,
  input  logic [DATA_W-1:0] MDR,
  input  logic [DATA_W-1:0] SRAM_Dq_in,
  output logic [ADDR_W-1:0] SRAM_Addr,
  output logic [DATA_W-1:0] SRAM_Dq_out,
  output logic              SRAM_Dq_oe,
  output logic              CE_n,
  output logic              OE_n,
  output logic              WE_n,
  output logic              UB_n,
  output logic              LB_n,
  output logic [DATA_W-1:0] Rd_data,
  output logic              Rd_valid,
  output logic              Wr_done,
  output logic              Busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_CAP   = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5,
    RELEASE  = 3'd6
  } state_t;

  // Last count value of each wait phase; the counter runs 0..N-1.
  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

  state_t            state, next_state;
  logic [3:0]        wait_cnt, next_cnt;
  logic              accept_rd, accept_wr;
  logic              nx_access, nx_read, nx_write, nx_pulse;
  logic [ADDR_W-1:0] mar_ext;

  // MAR is 16 bits; fit it to the SRAM address width.
  generate
    if (ADDR_W > 16) begin : g_zext
      assign mar_ext = {{(ADDR_W-16){1'b0}}, MAR};
    end else if (ADDR_W == 16) begin : g_same
      assign mar_ext = MAR;
    end else begin : g_trunc
      assign mar_ext = MAR[ADDR_W-1:0];
    end
  endgenerate

  // State and wait-counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  // Next-state logic; write wins when both strobes arrive together.
  always_comb begin
    next_state = state;
    next_cnt   = 4'd0;
    accept_rd  = 1'b0;
    accept_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_WE) begin
          next_state = WR_SETUP;
          accept_wr  = 1'b1;
        end else if (Mem_OE) begin
          next_state = RD;
          accept_rd  = 1'b1;
        end
      end
      RD: begin
        if (wait_cnt == RD_LAST) next_state = RD_CAP;
        else                     next_cnt   = wait_cnt + 4'd1;
      end
      RD_CAP:   next_state = RELEASE;
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: begin
        if (wait_cnt == WR_LAST) next_state = WR_HOLD;
        else                     next_cnt   = wait_cnt + 4'd1;
      end
      WR_HOLD:  next_state = RELEASE;
      RELEASE: begin
        if (!(Mem_OE || Mem_WE)) next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  // Pin decode of the state being entered, so every pin is a flop output.
  always_comb begin
    nx_read   = (next_state == RD) || (next_state == RD_CAP);
    nx_write  = (next_state == WR_SETUP) || (next_state == WR_PULSE) ||
                (next_state == WR_HOLD);
    nx_access = nx_read || nx_write;
    nx_pulse  = (next_state == WR_PULSE);
  end

  // SRAM control pins and Busy; reset releases the bus without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      CE_n       <= 1'b1;
      OE_n       <= 1'b1;
      WE_n       <= 1'b1;
      UB_n       <= 1'b1;
      LB_n       <= 1'b1;
      SRAM_Dq_oe <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      CE_n       <= !nx_access;
      OE_n       <= !nx_read;
      WE_n       <= !nx_pulse;
      UB_n       <= !nx_access;
      LB_n       <= !nx_access;
      SRAM_Dq_oe <= nx_write;
      Busy       <= (next_state != IDLE);
    end
  end

  // Address/data latch at acceptance, read capture and completion pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      SRAM_Addr   <= '0;
      SRAM_Dq_out <= '0;
      Rd_data     <= '0;
      Rd_valid    <= 1'b0;
      Wr_done     <= 1'b0;
    end else begin
      if (accept_rd || accept_wr) SRAM_Addr   <= mar_ext;
      if (accept_wr)              SRAM_Dq_out <= MDR;
      if (state == RD_CAP)        Rd_data     <= SRAM_Dq_in;
      Rd_valid <= (state == RD_CAP);
      Wr_done  <= (state == WR_HOLD);
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed table-driven bench for mem_access_sequencer
module tb_mem_access_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        Mem_OE, Mem_WE;
  logic [15:0] MAR, MDR, SRAM_Dq_in;
  logic [19:0] SRAM_Addr;
  logic [15:0] SRAM_Dq_out, Rd_data;
  logic        SRAM_Dq_oe, CE_n, OE_n, WE_n, UB_n, LB_n;
  logic        Rd_valid, Wr_done, Busy;

  mem_access_sequencer #(.ADDR_W(20), .DATA_W(16), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR(MDR), .SRAM_Dq_in(SRAM_Dq_in),
    .SRAM_Addr(SRAM_Addr), .SRAM_Dq_out(SRAM_Dq_out), .SRAM_Dq_oe(SRAM_Dq_oe),
    .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .UB_n(UB_n), .LB_n(LB_n),
    .Rd_data(Rd_data), .Rd_valid(Rd_valid), .Wr_done(Wr_done), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ctrl = {CE_n, OE_n, WE_n, UB_n, LB_n, SRAM_Dq_oe, Busy, Rd_valid, Wr_done}
  localparam logic [8:0] C_IDLE   = 9'b1_1_1_1_1_0_0_0_0;
  localparam logic [8:0] C_RD     = 9'b0_0_1_0_0_0_1_0_0;
  localparam logic [8:0] C_REL    = 9'b1_1_1_1_1_0_1_0_0;
  localparam logic [8:0] C_REL_RV = 9'b1_1_1_1_1_0_1_1_0;
  localparam logic [8:0] C_REL_WD = 9'b1_1_1_1_1_0_1_0_1;
  localparam logic [8:0] C_WSET   = 9'b0_1_1_0_0_1_1_0_0;
  localparam logic [8:0] C_WPUL   = 9'b0_1_0_0_0_1_1_0_0;
  localparam logic [8:0] C_WHOLD  = 9'b0_1_1_0_0_1_1_0_0;

  typedef struct {
    logic        oe;
    logic        we;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] dq_in;
    logic [8:0]  ctrl;
    logic [19:0] addr;
    logic [15:0] rd_data;
    logic [15:0] dq_out;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  function automatic vec_t mk(input logic oe, input logic we,
                              input logic [15:0] mar, input logic [15:0] mdr,
                              input logic [15:0] dq, input logic [8:0] c,
                              input logic [19:0] a, input logic [15:0] rd,
                              input logic [15:0] dqo);
    vec_t v;
    v.oe = oe; v.we = we; v.mar = mar; v.mdr = mdr; v.dq_in = dq;
    v.ctrl = c; v.addr = a; v.rd_data = rd; v.dq_out = dqo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [8:0] ctrl_now();
    return {CE_n, OE_n, WE_n, UB_n, LB_n, SRAM_Dq_oe, Busy, Rd_valid, Wr_done};
  endfunction

  // Bus protocol monitor: no bus fight, WE_n only low while driving a selected chip.
  always @(negedge Clk) begin
    if ((SRAM_Dq_oe && !OE_n) || (!WE_n && !(SRAM_Dq_oe && !CE_n))) begin
      viol++;
      $display("FAIL protocol at %0t: Dq_oe=%b OE_n=%b WE_n=%b CE_n=%b",
               $time, SRAM_Dq_oe, OE_n, WE_n, CE_n);
    end
  end

  int rv_cnt, busy_low;

  initial begin
    // Read, held 3 cycles, then back to IDLE
    vecs[0]  = mk(1, 0, 16'h0123, 16'h0000, 16'hBEEF, C_RD,     20'h00123, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 0, 16'h0123, 16'h0000, 16'hBEEF, C_RD,     20'h00123, 16'h0000, 16'h0000);
    vecs[2]  = mk(1, 0, 16'h0123, 16'h0000, 16'hBEEF, C_RD,     20'h00123, 16'h0000, 16'h0000);
    vecs[3]  = mk(0, 0, 16'h0123, 16'h0000, 16'hBEEF, C_REL_RV, 20'h00123, 16'hBEEF, 16'h0000);
    vecs[4]  = mk(0, 0, 16'h0123, 16'h0000, 16'hBEEF, C_IDLE,   20'h00123, 16'hBEEF, 16'h0000);
    // Write pulse; MAR/MDR scribbled after acceptance must be ignored
    vecs[5]  = mk(0, 1, 16'h0042, 16'h1234, 16'h0000, C_WSET,   20'h00042, 16'hBEEF, 16'h1234);
    vecs[6]  = mk(0, 0, 16'hFFFF, 16'hFFFF, 16'h0000, C_WPUL,   20'h00042, 16'hBEEF, 16'h1234);
    vecs[7]  = mk(0, 0, 16'hFFFF, 16'hFFFF, 16'h0000, C_WPUL,   20'h00042, 16'hBEEF, 16'h1234);
    vecs[8]  = mk(0, 0, 16'hFFFF, 16'hFFFF, 16'h0000, C_WHOLD,  20'h00042, 16'hBEEF, 16'h1234);
    vecs[9]  = mk(0, 0, 16'hFFFF, 16'hFFFF, 16'h0000, C_REL_WD, 20'h00042, 16'hBEEF, 16'h1234);
    vecs[10] = mk(0, 0, 16'hFFFF, 16'hFFFF, 16'h0000, C_IDLE,   20'h00042, 16'hBEEF, 16'h1234);
    // Both strobes together: write only, no Rd_valid
    vecs[11] = mk(1, 1, 16'h0005, 16'hA5A5, 16'h7777, C_WSET,   20'h00005, 16'hBEEF, 16'hA5A5);
    vecs[12] = mk(1, 1, 16'h0005, 16'hA5A5, 16'h7777, C_WPUL,   20'h00005, 16'hBEEF, 16'hA5A5);
    vecs[13] = mk(1, 1, 16'h0005, 16'hA5A5, 16'h7777, C_WPUL,   20'h00005, 16'hBEEF, 16'hA5A5);
    vecs[14] = mk(1, 1, 16'h0005, 16'hA5A5, 16'h7777, C_WHOLD,  20'h00005, 16'hBEEF, 16'hA5A5);
    vecs[15] = mk(1, 1, 16'h0005, 16'hA5A5, 16'h7777, C_REL_WD, 20'h00005, 16'hBEEF, 16'hA5A5);
    vecs[16] = mk(1, 1, 16'h0005, 16'hA5A5, 16'h7777, C_REL,    20'h00005, 16'hBEEF, 16'hA5A5);
    vecs[17] = mk(0, 0, 16'h0005, 16'hA5A5, 16'h7777, C_IDLE,   20'h00005, 16'hBEEF, 16'hA5A5);
    // MAR changes during RD; request drops mid-access but the read completes
    vecs[18] = mk(1, 0, 16'h0010, 16'h0000, 16'h5A5A, C_RD,     20'h00010, 16'hBEEF, 16'hA5A5);
    vecs[19] = mk(1, 0, 16'h0020, 16'h0000, 16'h5A5A, C_RD,     20'h00010, 16'hBEEF, 16'hA5A5);
    vecs[20] = mk(0, 0, 16'h0020, 16'h0000, 16'h5A5A, C_RD,     20'h00010, 16'hBEEF, 16'hA5A5);
    vecs[21] = mk(0, 0, 16'h0020, 16'h0000, 16'h5A5A, C_REL_RV, 20'h00010, 16'h5A5A, 16'hA5A5);
    vecs[22] = mk(0, 0, 16'h0020, 16'h0000, 16'h5A5A, C_IDLE,   20'h00010, 16'h5A5A, 16'hA5A5);

    Reset_n = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
    MAR = 16'h0; MDR = 16'h0; SRAM_Dq_in = 16'h0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_ctrl",    32'(ctrl_now()),   32'(C_IDLE));
    chk("reset_addr",    32'(SRAM_Addr),    32'h0);
    chk("reset_rd_data", 32'(Rd_data),      32'h0);
    chk("reset_dq_out",  32'(SRAM_Dq_out),  32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      Mem_OE = vecs[i].oe; Mem_WE = vecs[i].we;
      MAR = vecs[i].mar; MDR = vecs[i].mdr; SRAM_Dq_in = vecs[i].dq_in;
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_ctrl", i),    32'(ctrl_now()),  32'(vecs[i].ctrl));
      chk($sformatf("vec%0d_addr", i),    32'(SRAM_Addr),   32'(vecs[i].addr));
      chk($sformatf("vec%0d_rd_data", i), 32'(Rd_data),     32'(vecs[i].rd_data));
      chk($sformatf("vec%0d_dq_out", i),  32'(SRAM_Dq_out), 32'(vecs[i].dq_out));
    end

    // Mem_OE held 10 cycles: one read, Busy held until both strobes are low
    Mem_OE = 1'b1; Mem_WE = 1'b0; MAR = 16'h0077; SRAM_Dq_in = 16'h1111;
    rv_cnt = 0; busy_low = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk);
      #1;
      rv_cnt += int'(Rd_valid);
      if (!Busy) busy_low++;
    end
    chk("held_rd_valid_count", 32'(rv_cnt),   32'd1);
    chk("held_busy_low",       32'(busy_low), 32'd0);
    chk("held_rd_data",        32'(Rd_data),  32'h1111);
    Mem_OE = 1'b0; Mem_WE = 1'b1; MAR = 16'h0088; MDR = 16'h9999;
    @(posedge Clk);
    #1;
    chk("held_we_not_accepted", 32'(ctrl_now()), 32'(C_REL));
    chk("held_addr_unchanged",  32'(SRAM_Addr),  32'h00077);
    Mem_WE = 1'b0;
    @(posedge Clk);
    #1;
    chk("held_back_to_idle", 32'(ctrl_now()), 32'(C_IDLE));

    // Reset asserted between edges during WR_PULSE
    Mem_WE = 1'b1; MAR = 16'h0099; MDR = 16'h4321;
    @(posedge Clk);
    #1;
    Mem_WE = 1'b0;
    @(posedge Clk);
    #1;
    chk("pre_reset_we_low", 32'(WE_n), 32'd0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_pins", 32'({WE_n, SRAM_Dq_oe, CE_n, Busy}), 32'(4'b1010));
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("post_reset_ctrl",    32'(ctrl_now()),  32'(C_IDLE));
    chk("post_reset_rd_data", 32'(Rd_data),     32'h0);
    chk("post_reset_addr",    32'(SRAM_Addr),   32'h0);
    chk("post_reset_dq_out",  32'(SRAM_Dq_out), 32'h0);

    @(negedge Clk);
    chk("protocol_violations", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
